// File: rtl/rwt_tag_insert_mux_q.sv
// Tag/sample merge: queued tag beats are inserted directly ahead of the sample they annotate,
// with an optional packet-start alignment and a per-sample burst limit.
module rwt_tag_insert_mux_q #(
    parameter int DW        = 64,
    parameter int TW        = 7,
    parameter int TAG_DEPTH = 4,
    parameter int MAX_BURST = 1,
    parameter int ALIGN_SOP = 0
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic                             s_tag_valid,
    output logic                             s_tag_ready,
    input  logic [TW-1:0]                    s_tag_type,
    input  logic [DW-TW-2:0]                 s_tag_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DW-1:0]                    s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DW-1:0]                    m_data,
    output logic                             m_tag_valid,
    output logic [TW-1:0]                    m_tag_type,
    output logic                             m_last,
    output logic [$clog2(TAG_DEPTH+1)-1:0]   tag_level
);
    localparam int PW = DW - TW - 1;
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int LW = $clog2(TAG_DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [TW+PW-1:0] r_fifo [TAG_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [BW-1:0]    r_burst_cnt;
    logic             r_sop;

    logic             r_m_valid;
    logic             r_m_tag;
    logic             r_m_last;
    logic [DW-1:0]    r_m_data;
    logic             r_k_valid;
    logic             r_k_tag;
    logic             r_k_last;
    logic [DW-1:0]    r_k_data;

    logic             w_empty;
    logic             w_full;
    logic             w_elig;
    logic             w_skid_ready;
    logic             w_in_fire;
    logic [DW-1:0]    w_in_data;
    logic             w_in_last;
    logic             w_push;
    logic             w_pop;

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(TAG_DEPTH));
    assign w_elig       = !w_empty && s_valid && (r_burst_cnt < BW'(MAX_BURST))
                          && ((ALIGN_SOP == 0) || r_sop);
    // Input side sees only the registered skid state, so m_ready never reaches s_ready.
    assign w_skid_ready = !r_k_valid;
    assign w_in_fire    = s_valid && w_skid_ready;
    assign w_in_data    = w_elig ? {1'b0, r_fifo[r_rd_ptr]} : s_data;
    assign w_in_last    = !w_elig && s_last;
    assign w_push       = s_tag_valid && !w_full;
    assign w_pop        = w_in_fire && w_elig;

    assign s_tag_ready  = !w_full;
    assign s_ready      = s_valid && !w_elig && w_skid_ready;

    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_tag_valid  = r_m_tag;
    assign m_tag_type   = r_m_data[DW-2 -: TW];
    assign m_last       = r_m_last;
    assign tag_level    = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {s_tag_type, s_tag_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_burst_cnt <= '0;
            r_sop       <= 1'b1;
        end else if (w_in_fire) begin
            if (w_elig) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
                r_burst_cnt <= '0;
                r_sop       <= s_last;
            end
        end
    end

    // Skid register absorbs the beat accepted in the cycle the main register stalls.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_m_valid <= 1'b0;
            r_m_tag   <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_k_valid <= 1'b0;
            r_k_tag   <= 1'b0;
            r_k_last  <= 1'b0;
            r_k_data  <= '0;
        end else if (!r_m_valid || m_ready) begin
            if (r_k_valid) begin
                r_m_valid <= 1'b1;
                r_m_tag   <= r_k_tag;
                r_m_last  <= r_k_last;
                r_m_data  <= r_k_data;
                r_k_valid <= 1'b0;
            end else begin
                r_m_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_m_tag  <= w_elig;
                    r_m_last <= w_in_last;
                    r_m_data <= w_in_data;
                end
            end
        end else if (w_in_fire) begin
            r_k_valid <= 1'b1;
            r_k_tag   <= w_elig;
            r_k_last  <= w_in_last;
            r_k_data  <= w_in_data;
        end
    end
endmodule

// File: tb/tb_rwt_tag_insert_mux_q.sv
// Three configurations (default, MAX_BURST=3, ALIGN_SOP=1) checked against a beat-level
// scoreboard plus directed sequences with literal expectations.
module tb_rwt_tag_insert_mux_q;
    localparam int N  = 3;
    localparam int QD = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn     [N];
    logic        s_tag_valid [N];
    logic        s_tag_ready [N];
    logic [6:0]  s_tag_type  [N];
    logic [55:0] s_tag_data  [N];
    logic        s_valid     [N];
    logic        s_ready     [N];
    logic [63:0] s_data      [N];
    logic        s_last      [N];
    logic        m_valid     [N];
    logic        m_ready     [N];
    logic [63:0] m_data      [N];
    logic        m_tag_valid [N];
    logic [6:0]  m_tag_type  [N];
    logic        m_last      [N];
    logic [2:0]  tag_level   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        rwt_tag_insert_mux_q #(
            .DW(64), .TW(7), .TAG_DEPTH(4),
            .MAX_BURST((g == 1) ? 3 : 1),
            .ALIGN_SOP((g == 2) ? 1 : 0)
        ) u_dut (
            .clk(clk), .aresetn(aresetn[g]),
            .s_tag_valid(s_tag_valid[g]), .s_tag_ready(s_tag_ready[g]),
            .s_tag_type(s_tag_type[g]), .s_tag_data(s_tag_data[g]),
            .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_data(s_data[g]), .s_last(s_last[g]),
            .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]),
            .m_tag_valid(m_tag_valid[g]), .m_tag_type(m_tag_type[g]), .m_last(m_last[g]),
            .tag_level(tag_level[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int mb(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    // Scoreboard: accepted tags and samples in arrival order, output beats drawn from them.
    logic [62:0] mq_tag [N][QD];
    logic [64:0] mq_smp [N][QD];
    int          mt_h [N] = '{0, 0, 0};
    int          mt_t [N] = '{0, 0, 0};
    int          ms_h [N] = '{0, 0, 0};
    int          ms_t [N] = '{0, 0, 0};
    int          m_burst [N] = '{0, 0, 0};
    bit          m_sop   [N] = '{1, 1, 1};
    bit          p_stall [N] = '{0, 0, 0};
    logic [63:0] p_data  [N];
    logic        p_tag   [N];
    logic        p_last  [N];

    logic [63:0] log_d [N][64];
    logic        log_t [N][64];
    logic        log_l [N][64];
    int          log_n [N] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!aresetn[k]) begin
                mt_h[k] = 0; mt_t[k] = 0; ms_h[k] = 0; ms_t[k] = 0;
                m_burst[k] = 0; m_sop[k] = 1'b1; p_stall[k] = 1'b0;
            end else begin
                chk("level_bound", k, 64'(int'(tag_level[k]) <= (mt_t[k] - mt_h[k])), 64'd1);
                chk("tag_ready", k, 64'(s_tag_ready[k]), 64'(tag_level[k] != 3'd4));
                if (s_tag_valid[k] && s_tag_ready[k]) begin
                    mq_tag[k][mt_t[k] % QD] = {s_tag_type[k], s_tag_data[k]};
                    mt_t[k]++;
                end
                if (s_valid[k] && s_ready[k]) begin
                    mq_smp[k][ms_t[k] % QD] = {s_last[k], s_data[k]};
                    ms_t[k]++;
                end
                if (p_stall[k]) begin
                    chk("stall_data", k, m_data[k], p_data[k]);
                    chk("stall_flags", k, 64'({m_valid[k], m_tag_valid[k], m_last[k]}),
                        64'({1'b1, p_tag[k], p_last[k]}));
                end
                if (m_valid[k] && m_ready[k]) begin
                    if (log_n[k] < 64) begin
                        log_d[k][log_n[k]] = m_data[k];
                        log_t[k][log_n[k]] = m_tag_valid[k];
                        log_l[k][log_n[k]] = m_last[k];
                        log_n[k]++;
                    end
                    if (m_tag_valid[k]) begin
                        chk("tag_avail", k, 64'(mt_t[k] != mt_h[k]), 64'd1);
                        if (mt_t[k] != mt_h[k]) begin
                            chk("tag_data", k, m_data[k], {1'b0, mq_tag[k][mt_h[k] % QD]});
                            chk("tag_type", k, 64'(m_tag_type[k]), 64'(mq_tag[k][mt_h[k] % QD][62:56]));
                            mt_h[k]++;
                        end
                        chk("tag_last", k, 64'(m_last[k]), 64'd0);
                        chk("burst_lim", k, 64'(m_burst[k] < mb(k)), 64'd1);
                        if (k == 2) chk("sop_align", k, 64'(m_sop[k]), 64'd1);
                        m_burst[k]++;
                    end else begin
                        chk("smp_avail", k, 64'(ms_t[k] != ms_h[k]), 64'd1);
                        if (ms_t[k] != ms_h[k]) begin
                            chk("smp_data", k, m_data[k], mq_smp[k][ms_h[k] % QD][63:0]);
                            chk("smp_last", k, 64'(m_last[k]), 64'(mq_smp[k][ms_h[k] % QD][64]));
                            m_sop[k] = mq_smp[k][ms_h[k] % QD][64];
                            ms_h[k]++;
                        end
                        m_burst[k] = 0;
                    end
                end
                p_stall[k] = m_valid[k] && !m_ready[k];
                p_data[k]  = m_data[k];
                p_tag[k]   = m_tag_valid[k];
                p_last[k]  = m_last[k];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input int k, input logic [6:0] ty, input logic [55:0] pl);
        bit hs = 1'b0;
        s_tag_valid[k] = 1'b1; s_tag_type[k] = ty; s_tag_data[k] = pl;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk);
            hs = s_tag_valid[k] && s_tag_ready[k];
            @(posedge clk); #1;
        end
        s_tag_valid[k] = 1'b0;
        chk("push_hs", k, 64'(hs), 64'd1);
    endtask

    task automatic send_sample(input int k, input logic [63:0] d, input logic l);
        bit hs = 1'b0;
        s_valid[k] = 1'b1; s_data[k] = d; s_last[k] = l;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk);
            hs = s_valid[k] && s_ready[k];
            @(posedge clk); #1;
        end
        s_valid[k] = 1'b0;
        chk("sample_hs", k, 64'(hs), 64'd1);
    endtask

    task automatic rand_run(input int k, input int nbeats);
        int done_n = 0;
        int cyc = 0;
        bit th, sh;
        while (done_n < nbeats && cyc < 60000) begin
            @(negedge clk);
            th = s_tag_valid[k] && s_tag_ready[k];
            sh = s_valid[k] && s_ready[k];
            @(posedge clk); #1;
            cyc++;
            if (th) done_n++;
            if (sh) done_n++;
            if (th || !s_tag_valid[k]) begin
                s_tag_valid[k] = ($urandom_range(7) == 0);
                s_tag_type[k]  = 7'($urandom);
                s_tag_data[k]  = 56'({$urandom, $urandom});
            end
            if (sh || !s_valid[k]) begin
                s_valid[k] = ($urandom_range(3) != 0);
                s_data[k]  = {$urandom, $urandom};
                s_last[k]  = ($urandom_range(4) == 0);
            end
            m_ready[k] = 1'($urandom_range(1));
        end
        chk("rand_budget", k, 64'(done_n >= nbeats), 64'd1);
        s_tag_valid[k] = 1'b0;
        s_valid[k]     = 1'b0;
        m_ready[k]     = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            aresetn[k] = 1'b0; s_tag_valid[k] = 1'b0; s_tag_type[k] = '0; s_tag_data[k] = '0;
            s_valid[k] = 1'b0; s_data[k] = '0; s_last[k] = 1'b0; m_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) aresetn[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_m_valid", k, 64'(m_valid[k]), 64'd0);
            chk("rst_tag_ready", k, 64'(s_tag_ready[k]), 64'd1);
            chk("rst_s_ready", k, 64'(s_ready[k]), 64'd0);
            chk("rst_level", k, 64'(tag_level[k]), 64'd0);
            chk("rst_m_data", k, m_data[k], 64'd0);
            chk("rst_flags", k, 64'({m_tag_valid[k], m_last[k]}), 64'd0);
        end
        @(posedge clk); #1;

        // T1: single tag ahead of its sample
        log_n[0] = 0;
        push_tag(0, 7'h05, 56'h11223344556677);
        send_sample(0, 64'hAAAAAAAAAAAAAAAA, 1'b1);
        idle(4);
        chk("t1_count", 0, 64'(log_n[0]), 64'd2);
        chk("t1_tag_data", 0, log_d[0][0], 64'h0511223344556677);
        chk("t1_tag_flag", 0, 64'({log_t[0][0], log_l[0][0]}), 64'b10);
        chk("t1_smp_data", 0, log_d[0][1], 64'hAAAAAAAAAAAAAAAA);
        chk("t1_smp_flag", 0, 64'({log_t[0][1], log_l[0][1]}), 64'b01);

        // T2: fill FIFO, stalled fifth push, then alternate tag/sample
        log_n[0] = 0;
        for (int i = 1; i <= 4; i++) push_tag(0, 7'(i), 56'(i));
        @(negedge clk);
        chk("t2_level_full", 0, 64'(tag_level[0]), 64'd4);
        @(posedge clk); #1;
        s_tag_valid[0] = 1'b1; s_tag_type[0] = 7'h09; s_tag_data[0] = 56'h9;
        repeat (3) begin
            @(negedge clk);
            chk("t2_full_stall", 0, 64'(s_tag_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        s_tag_valid[0] = 1'b0;
        for (int j = 0; j < 4; j++) send_sample(0, 64'hB0 + 64'(j), 1'(j == 3));
        idle(4);
        @(negedge clk);
        chk("t2_level_empty", 0, 64'(tag_level[0]), 64'd0);
        chk("t2_count", 0, 64'(log_n[0]), 64'd8);
        for (int j = 0; j < 4; j++) begin
            chk("t2_tag", 0, log_d[0][2*j], {1'b0, 7'(j + 1), 56'(j + 1)});
            chk("t2_smp", 0, {log_d[0][2*j+1][62:0], log_t[0][2*j+1]}, {63'(64'hB0 + 64'(j)), 1'b0});
        end
        @(posedge clk); #1;

        // T3: burst of three tags before one sample
        log_n[1] = 0;
        for (int i = 1; i <= 3; i++) push_tag(1, 7'(i), 56'h100 + 56'(i));
        send_sample(1, 64'hC3, 1'b1);
        idle(6);
        chk("t3_count", 1, 64'(log_n[1]), 64'd4);
        for (int i = 0; i < 3; i++) chk("t3_tag", 1, log_d[1][i], {1'b0, 7'(i + 1), 56'h100 + 56'(i + 1)});
        chk("t3_smp", 1, {log_d[1][3][62:0], log_t[1][3]}, {63'h0C3, 1'b0});

        // T4: tag posted mid-packet appears ahead of the next packet
        log_n[2] = 0;
        for (int j = 0; j < 3; j++) send_sample(2, 64'h40 + 64'(j), 1'b0);
        push_tag(2, 7'h2A, 56'hA4);
        for (int j = 3; j < 8; j++) send_sample(2, 64'h40 + 64'(j), 1'(j == 7));
        for (int j = 0; j < 8; j++) send_sample(2, 64'h50 + 64'(j), 1'(j == 7));
        idle(4);
        chk("t4_count", 2, 64'(log_n[2]), 64'd17);
        begin
            int ntag = 0;
            for (int j = 0; j < 8; j++) ntag += int'(log_t[2][j]);
            chk("t4_no_midpkt_tag", 2, 64'(ntag), 64'd0);
        end
        chk("t4_tag", 2, {log_d[2][8][62:0], log_t[2][8]}, {63'({7'h2A, 56'hA4}), 1'b1});
        chk("t4_next_sop", 2, log_d[2][9], 64'h50);

        // T5: randomized traffic with back-pressure on all three configurations
        fork
            rand_run(0, 10000);
            rand_run(1, 3000);
            rand_run(2, 3000);
        join
        idle(40);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("t5_smp_drained", k, 64'(ms_t[k] - ms_h[k]), 64'd0);
            chk("t5_level_left", k, 64'(tag_level[k]), 64'(mt_t[k] - mt_h[k]));
        end
        @(posedge clk); #1;

        // T6: reset with tags queued and a held output beat
        aresetn[0] = 1'b0;
        idle(2);
        aresetn[0] = 1'b1;
        idle(1);
        m_ready[0] = 1'b0;
        send_sample(0, 64'hD6, 1'b0);
        for (int i = 1; i <= 3; i++) push_tag(0, 7'(i), 56'(i));
        @(negedge clk);
        chk("t6_pre_valid", 0, 64'(m_valid[0]), 64'd1);
        chk("t6_pre_level", 0, 64'(tag_level[0]), 64'd3);
        @(posedge clk); #1;
        aresetn[0] = 1'b0;
        @(posedge clk); #1;
        aresetn[0] = 1'b1;
        @(negedge clk);
        chk("t6_m_valid", 0, 64'(m_valid[0]), 64'd0);
        chk("t6_level", 0, 64'(tag_level[0]), 64'd0);
        chk("t6_tag_ready", 0, 64'(s_tag_ready[0]), 64'd1);
        @(posedge clk); #1;
        m_ready[0] = 1'b1;
        log_n[0] = 0;
        idle(4);
        chk("t6_no_beat", 0, 64'(log_n[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
